// File: rtl/pll_clken_pkg.sv
// -----------------------------------------------------------------------------
// pll_clken_pkg
// Shared definitions for the PLL-qualified fractional clock-enable generator.
// Contents:
//   state_t      lock qualification FSM states (WAIT_LOCK, HOLD, RUN)
//   DEF_*        default values for the generator parameters
//   chSelWidth   width of the channel-select bus for a given channel count
// Optional build macro used by the generator: PLL_CLKEN_LOCKCNT_EN
// -----------------------------------------------------------------------------
package pll_clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_LOCK_HOLD = 1024;
  localparam int LOSS_CNT_W    = 8;

  // A single-channel build still needs a 1-bit select port.
  function automatic int chSelWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/pll_clken_acc.sv
// -----------------------------------------------------------------------------
// pll_clken_acc
// One channel of the fractional clock-enable generator: holds the programmed
// rate increment, the programmed start phase and the running phase
// accumulator. The carry out of each accumulator add becomes a one-cycle
// clock-enable pulse on the following cycle.
// Ports:
//   i_clk    clock (rising edge)
//   i_rst    synchronous reset, active-high
//   i_we     write strobe for this channel's inc/phase registers
//   i_inc    rate increment to store on i_we
//   i_phase  start phase to store on i_we
//   i_load   reload the accumulator from the stored phase (no add this cycle)
//   i_step   perform one accumulator add this cycle
//   o_ce     registered clock-enable pulse
// -----------------------------------------------------------------------------
module pll_clken_acc
  import pll_clken_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_phase,
  input  logic             i_load,
  input  logic             i_step,
  output logic             o_ce
);

  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_phase;
  logic [ACC_W-1:0] r_acc;
  logic             r_ce;
  logic [ACC_W:0]   w_sum;

  // One extra bit captures the wrap of the modulo-2^ACC_W accumulator.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  // Configuration registers. A write in the same cycle as a reload lands at
  // this edge, so the reload below still sees the previous phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inc   <= '0;
      r_phase <= '0;
    end else if (i_we) begin
      r_inc   <= i_inc;
      r_phase <= i_phase;
    end
  end

  // Accumulator and pulse output. A reload suppresses the add so that all
  // channels restart from their phases together; when idle the accumulator
  // simply holds and no pulse is produced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else if (i_load) begin
      r_acc <= r_phase;
      r_ce  <= 1'b0;
    end else if (i_step) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ce  <= w_sum[ACC_W];
    end else begin
      r_ce  <= 1'b0;
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/pll_clken_gen.sv
// -----------------------------------------------------------------------------
// pll_clken_gen
// Multi-channel fractional clock-enable generator qualified by PLL lock.
// Each channel pulses at refclk * inc / 2^ACC_W. Pulses are only produced once
// the synchronised PLL lock has been stable for LOCK_HOLD cycles, and stop as
// soon as the lock drops.
// Ports:
//   refclk         the only clock, rising edge
//   rst            synchronous reset, active-high
//   pll_locked     raw asynchronous PLL lock indicator
//   cfg_we         write strobe for channel cfg_ch
//   cfg_ch         channel select (selects beyond NUM_CH-1 write nothing)
//   cfg_inc        rate increment to write
//   cfg_phase      start phase to write
//   cfg_resync     pulse: reload every accumulator from its stored phase
//   ce             per-channel registered clock-enable pulses
//   locked         high while the generator is running
//   lost_lock      sticky flag: lock dropped while running
//   lock_loss_cnt  saturating count of running->unlocked transitions
//                  (present only when PLL_CLKEN_LOCKCNT_EN is defined)
// Build macro: PLL_CLKEN_LOCKCNT_EN
// -----------------------------------------------------------------------------
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic                            pll_locked,
  input  logic                            cfg_we,
  input  logic [chSelWidth(NUM_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]                cfg_inc,
  input  logic [ACC_W-1:0]                cfg_phase,
  input  logic                            cfg_resync,
  output logic [NUM_CH-1:0]               ce,
  output logic                            locked,
  output logic                            lost_lock
`ifdef PLL_CLKEN_LOCKCNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]           lock_loss_cnt
`endif
);

  localparam int CH_W = chSelWidth(NUM_CH);
  localparam int HOLD_W = $clog2(LOCK_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic              r_lkMeta;
  logic              r_lkSync;
  state_t            r_state;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_locked;
  logic              r_lostLock;
`ifdef PLL_CLKEN_LOCKCNT_EN
  logic [LOSS_CNT_W-1:0] r_lossCnt;
`endif

  logic w_runEntry;
  logic w_runActive;
  logic w_load;
  logic w_step;

  // Two-flop synchroniser for the asynchronous lock input; the FSM only ever
  // looks at the synchronised copy.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lkMeta <= 1'b0;
      r_lkSync <= 1'b0;
    end else begin
      r_lkMeta <= pll_locked;
      r_lkSync <= r_lkMeta;
    end
  end

  // Accumulators step only while running with lock still present. RUN entry
  // and resync both reload from the stored phases instead of adding, which is
  // what keeps every channel aligned to a common starting point.
  assign w_runEntry  = (r_state == HOLD) && r_lkSync && (r_holdCnt == HOLD_LAST);
  assign w_runActive = (r_state == RUN) && r_lkSync;
  assign w_load      = w_runEntry || (w_runActive && cfg_resync);
  assign w_step      = w_runActive && !cfg_resync;

  // Lock qualification FSM. The hold counter must see LOCK_HOLD consecutive
  // locked cycles; any dropout in HOLD starts over without flagging a loss,
  // while a dropout in RUN is recorded as a lost lock.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state    <= WAIT_LOCK;
      r_holdCnt  <= '0;
      r_locked   <= 1'b0;
      r_lostLock <= 1'b0;
`ifdef PLL_CLKEN_LOCKCNT_EN
      r_lossCnt  <= '0;
`endif
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_holdCnt <= '0;
          if (r_lkSync) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!r_lkSync) begin
            r_state   <= WAIT_LOCK;
            r_holdCnt <= '0;
          end else if (r_holdCnt == HOLD_LAST) begin
            r_state  <= RUN;
            r_locked <= 1'b1;
          end else begin
            r_holdCnt <= r_holdCnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!r_lkSync) begin
            r_state    <= WAIT_LOCK;
            r_holdCnt  <= '0;
            r_locked   <= 1'b0;
            r_lostLock <= 1'b1;
`ifdef PLL_CLKEN_LOCKCNT_EN
            if (r_lossCnt != {LOSS_CNT_W{1'b1}}) begin
              r_lossCnt <= r_lossCnt + LOSS_CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          r_state   <= WAIT_LOCK;
          r_holdCnt <= '0;
          r_locked  <= 1'b0;
        end
      endcase
    end
  end

  // One accumulator channel per clock-enable output. Each channel decodes its
  // own write strobe, so selects past the last channel match nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pll_clken_acc #(
      .ACC_W(ACC_W)
    ) u_acc (
      .i_clk  (refclk),
      .i_rst  (rst),
      .i_we   (cfg_we && (cfg_ch == CH_W'(gi))),
      .i_inc  (cfg_inc),
      .i_phase(cfg_phase),
      .i_load (w_load),
      .i_step (w_step),
      .o_ce   (ce[gi])
    );
  end

  assign locked    = r_locked;
  assign lost_lock = r_lostLock;
`ifdef PLL_CLKEN_LOCKCNT_EN
  assign lock_loss_cnt = r_lossCnt;
`endif

endmodule

// File: tb/tb_pll_clken_gen.sv
// -----------------------------------------------------------------------------
// tb_pll_clken_gen
// Scoreboard bench for pll_clken_gen. Stimulus pushes expected observations,
// tagged with the cycle they must appear in, into a queue; a monitor samples
// the DUT on every falling edge and compares the entries that fall due.
// Uses NUM_CH=3 so that channel select 3 is an out-of-range write.
// Build macro: PLL_CLKEN_LOCKCNT_EN (also enables the lock-loss counter phase)
// -----------------------------------------------------------------------------
module tb_pll_clken_gen;

  localparam int NUM_CH    = 3;
  localparam int ACC_W     = 24;
  localparam int LOCK_HOLD = 16;

  // Observation selectors for scoreboard entries.
  localparam int SIG_CE     = 0;
  localparam int SIG_LOCKED = 1;
  localparam int SIG_LOST   = 2;
  localparam int SIG_LCNT   = 3;
  localparam int SIG_WIN    = 10;

  typedef struct {
    string name;
    int    cyc;
    int    sig;
    int    lo;
    int    hi;
    int    from;
  } exp_t;

  logic              refclk;
  logic              rst;
  logic              pll_locked;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic              cfg_resync;
  logic [NUM_CH-1:0] ce;
  logic              locked;
  logic              lost_lock;
`ifdef PLL_CLKEN_LOCKCNT_EN
  logic [7:0]        lock_loss_cnt;
`endif

  exp_t sbq[$];
  logic [NUM_CH-1:0] ceHist [int];
  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  // Expected ce vectors for 9 cycles starting at the resync edge.
  int patA[9] = '{0, 0, 2, 0, 1, 0, 2, 0, 1};
  int patB[9] = '{0, 0, 2, 1, 0, 0, 2, 1, 0};
  int rateCe[6] = '{0, 1, 0, 3, 0, 1};

  pll_clken_gen #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_HOLD(LOCK_HOLD)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_resync(cfg_resync),
    .ce        (ce),
    .locked    (locked),
    .lost_lock (lost_lock)
`ifdef PLL_CLKEN_LOCKCNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  // Free-running 100 MHz reference clock and a cycle index of rising edges.
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk) cyc <= cyc + 1;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int windowCount(input int bitIdx, input int fromCyc, input int toCyc);
    int n = 0;
    for (int c = fromCyc; c <= toCyc; c++) begin
      if (ceHist.exists(c) && ceHist[c][bitIdx]) n++;
    end
    return n;
  endfunction

  // Compare one due scoreboard entry against what the DUT shows now.
  task automatic checkOutput(input exp_t e);
    int act;
    act = 0;
    case (e.sig)
      SIG_CE:     act = int'(ce);
      SIG_LOCKED: act = int'(locked);
      SIG_LOST:   act = int'(lost_lock);
`ifdef PLL_CLKEN_LOCKCNT_EN
      SIG_LCNT:   act = int'(lock_loss_cnt);
`endif
      default:    act = windowCount(e.sig - SIG_WIN, e.from, cyc);
    endcase
    nCompared++;
    if (act < e.lo || act > e.hi) begin
      nMismatched++;
      $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d..%0d", e.name, cyc, act, e.lo, e.hi);
    end
  endtask

  // Monitor: record the ce history, then retire every entry due this cycle.
  initial begin
    forever begin
      @(negedge refclk);
      ceHist[cyc] = ce;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          checkOutput(sbq[i]);
          sbq.delete(i);
        end
      end
    end
  end

  task automatic expectAt(input string name, input int dly, input int sig,
                          input int lo, input int hi, input int from = 0);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.lo   = lo;
    e.hi   = hi;
    e.from = from;
    sbq.push_back(e);
  endtask

  task automatic pushPattern(input string name, input int pat[9]);
    for (int k = 0; k < 9; k++) expectAt(name, 1 + k, SIG_CE, pat[k], pat[k]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Drive one cycle of configuration/resync, then return inputs to idle.
  task automatic applyStimulus(input logic we, input logic [1:0] ch,
                               input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph,
                               input logic resync);
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_inc    = inc;
    cfg_phase  = ph;
    cfg_resync = resync;
    @(negedge refclk);
    cfg_we     = 1'b0;
    cfg_resync = 1'b0;
  endtask

  initial begin
    int t0;
    rst        = 1'b1;
    pll_locked = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_inc    = '0;
    cfg_phase  = '0;
    cfg_resync = 1'b0;

    // Reset state.
    @(negedge refclk);
    expectAt("rstCe", 1, SIG_CE, 0, 0);
    expectAt("rstLocked", 1, SIG_LOCKED, 0, 0);
    expectAt("rstLost", 1, SIG_LOST, 0, 0);
`ifdef PLL_CLKEN_LOCKCNT_EN
    expectAt("rstLossCnt", 1, SIG_LCNT, 0, 0);
`endif
    tick(2);
    rst = 1'b0;

    // Program rates while still unlocked.
    applyStimulus(1'b1, 2'd0, 24'h800000, 24'h000000, 1'b0);
    applyStimulus(1'b1, 2'd1, 24'h555555, 24'h000000, 1'b0);

    // Lock qualification and rate: RUN entry 19 cycles after lock rises.
    pll_locked = 1'b1;
    t0 = cyc;
    for (int d = 1; d <= 18; d++) expectAt("ceBeforeRun", d, SIG_CE, 0, 0);
    expectAt("lockedEarly", 18, SIG_LOCKED, 0, 0);
    expectAt("lockedRise", 19, SIG_LOCKED, 1, 1);
    for (int k = 0; k < 6; k++) expectAt("rateCe", 20 + k, SIG_CE, rateCe[k], rateCe[k]);
    expectAt("rateCh0Win", 19 + 3000, SIG_WIN + 0, 1500, 1500, t0 + 20);
    expectAt("rateCh1Win", 19 + 3000, SIG_WIN + 1, 999, 1001, t0 + 20);
    tick(3025);

    // Phase alignment and resync after a rate change.
    applyStimulus(1'b1, 2'd0, 24'h400000, 24'h000000, 1'b0);
    applyStimulus(1'b1, 2'd1, 24'h400000, 24'h800000, 1'b0);
    pushPattern("align", patA);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    tick(12);
    applyStimulus(1'b1, 2'd0, 24'h300000, 24'h000000, 1'b0);
    tick(7);
    applyStimulus(1'b1, 2'd0, 24'h400000, 24'h000000, 1'b0);
    pushPattern("realign", patA);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    tick(12);

    // Simultaneous write and resync: reload uses the old phase.
    pushPattern("syncOldPhase", patA);
    applyStimulus(1'b1, 2'd0, 24'h400000, 24'h400000, 1'b1);
    tick(12);
    pushPattern("syncNewPhase", patB);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    tick(12);

    // Out-of-range channel write changes nothing.
    applyStimulus(1'b1, 2'd3, 24'hFFFFFF, 24'h123456, 1'b0);
    pushPattern("oobIgnored", patB);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    tick(12);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    expectAt("lockedHeld", 2, SIG_LOCKED, 1, 1);
    expectAt("lockedDrop", 3, SIG_LOCKED, 0, 0);
    expectAt("ceDrop", 3, SIG_CE, 0, 0);
    expectAt("lostSet", 3, SIG_LOST, 1, 1);
    expectAt("lostSticky", 20, SIG_LOST, 1, 1);
    expectAt("ceIdle", 20, SIG_CE, 0, 0);
`ifdef PLL_CLKEN_LOCKCNT_EN
    expectAt("lossCnt1", 5, SIG_LCNT, 1, 1);
`endif
    tick(25);

    // Reset clears the sticky flag.
    rst = 1'b1;
    expectAt("rst2Lost", 1, SIG_LOST, 0, 0);
    expectAt("rst2Locked", 1, SIG_LOCKED, 0, 0);
    tick(2);
    rst = 1'b0;

    // Dropout during HOLD is not a lost lock.
    pll_locked = 1'b1;
    tick(8);
    pll_locked = 1'b0;
    expectAt("holdDropLocked", 25, SIG_LOCKED, 0, 0);
    expectAt("holdDropLost", 25, SIG_LOST, 0, 0);
    tick(30);

    // Relock with cleared rates: RUN but no pulses.
    pll_locked = 1'b1;
    expectAt("relockEarly", 18, SIG_LOCKED, 0, 0);
    expectAt("relockRise", 19, SIG_LOCKED, 1, 1);
    for (int d = 20; d <= 26; d++) expectAt("ceZeroInc", d, SIG_CE, 0, 0);
    tick(28);

    // Reset while running: lock must be requalified from scratch.
    rst = 1'b1;
    expectAt("rstRunLocked", 1, SIG_LOCKED, 0, 0);
    tick(2);
    rst = 1'b0;
    expectAt("requalEarly", 18, SIG_LOCKED, 0, 0);
    expectAt("requalRise", 19, SIG_LOCKED, 1, 1);
    expectAt("requalLost", 19, SIG_LOST, 0, 0);
    tick(25);

`ifdef PLL_CLKEN_LOCKCNT_EN
    // 300 lock losses saturate the counter at 255; reset clears it.
    pll_locked = 1'b0;
    tick(4);
    expectAt("lossCntFirst", 1, SIG_LCNT, 1, 1);
    for (int n = 1; n < 300; n++) begin
      pll_locked = 1'b1;
      tick(20);
      pll_locked = 1'b0;
      tick(4);
    end
    expectAt("lossCntSat", 1, SIG_LCNT, 255, 255);
    tick(2);
    rst = 1'b1;
    expectAt("lossCntRst", 1, SIG_LCNT, 0, 0);
    tick(2);
    rst = 1'b0;
`endif

    tick(5);
    foreach (sbq[i]) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: got no sample at cyc %0d, expected one", sbq[i].name, sbq[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
